ffstdp_update_ctrl: RTL
=======================

FFSTDP_UPDATE_CTRL -- requirements
Module: ffstdp_update_ctrl

Interface
REQ-001 SHALL have parameter PRE_ADDR_W, default 8, log2 of pre-synaptic neuron count (N_PRE = 2^PRE_ADDR_W).
REQ-002 SHALL have parameter POST_ADDR_W, default 7, log2 of post-synaptic neuron count (N_POST = 2^POST_ADDR_W).
REQ-003 SHALL have parameters PRE_CNT_WIDTH 8, POST_CNT_WIDTH 7, WEIGHT_WIDTH 8; these are spike-count and signed weight widths.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, with ports named as follows:
  CLK  in  1  clock, rising edge
  RST_N  in  1  asynchronous active-low reset
  START  in  1  one-cycle pulse at end of a sample window (timestep reference event)
  IS_TRAIN  in  1  training enable, sampled with START
  IS_POS  in  1  positive or negative sample, sampled with START
  BUSY  out  1  high from the cycle after an accepted START until the DONE cycle, inclusive
  DONE  out  1  one-cycle completion pulse
  POST_CNT_ADDR  out  POST_ADDR_W  post spike-count memory address
  POST_CNT_RDATA  in  POST_CNT_WIDTH  count, valid 1 cycle after address
  PRE_CNT_ADDR  out  PRE_ADDR_W  pre spike-count memory address
  PRE_CNT_RDATA  in  PRE_CNT_WIDTH  count, valid 1 cycle after address
  SRAM_CS  out  1  synapse SRAM select
  SRAM_WE  out  1  synapse SRAM write enable
  SRAM_ADDR  out  POST_ADDR_W+PRE_ADDR_W  synapse address, {post, pre}
  SRAM_WDATA  out  WEIGHT_WIDTH  updated weight
  SRAM_RDATA  in  WEIGHT_WIDTH  signed weight, valid 1 cycle after a read

Function
REQ-005 SHALL have FSM states IDLE, POST_RD, POST_CHK, SYN_RD, SYN_WR and FIN.
REQ-006 IDLE: START=1 and IS_TRAIN=1 SHALL latch IS_POS, clear post index p=0 and go to POST_RD.
REQ-007 IDLE: START=1 and IS_TRAIN=0 SHALL go to FIN with no memory access.
REQ-008 START while BUSY=1 SHALL be ignored, with no effect on indices or latched IS_POS.
REQ-009 POST_RD: SHALL drive POST_CNT_ADDR=p, then go to POST_CHK.
REQ-010 POST_CHK: if POST_CNT_RDATA==0, SHALL skip neuron p:
  - p==N_POST-1 goes to FIN; otherwise p++ and go to POST_RD.
  - Else SHALL register the post count, set pre index i=0 and go to SYN_RD.
REQ-011 SYN_RD: SHALL drive SRAM_CS=1, SRAM_WE=0, SRAM_ADDR={p,i} and PRE_CNT_ADDR=i in the same cycle, then go to SYN_WR.
REQ-012 SYN_WR: SHALL feed SRAM_RDATA, PRE_CNT_RDATA, the registered post count, latched IS_POS, IS_TRAIN=1 and TREF_EVENT=1 to the update datapath.
REQ-013 SYN_WR: SHALL drive SRAM_CS=1, SRAM_ADDR={p,i} and SRAM_WDATA=datapath output.
  - SRAM_WE=1 only if PRE_CNT_RDATA!=0; a zero pre count suppresses the write.
REQ-014 SYN_WR exit: if i==N_PRE-1, follow the p rules of REQ-010 (FIN or POST_RD with p++); otherwise i++ and go to SYN_RD.
REQ-015 FIN: SHALL assert DONE=1 for exactly one cycle, then go to IDLE.
REQ-016 Latency: FIN cycle count = 1 + sum over post neurons of (2 if count==0 else 2+2*N_PRE); the IS_TRAIN=0 path is exactly 1 cycle.
REQ-017 Index counters SHALL wrap only via the FSM exit conditions and never overflow silently.
REQ-018 SRAM_CS and SRAM_WE SHALL be 0 in every state except SYN_RD and SYN_WR.
REQ-019 Saturation: weight arithmetic and saturation SHALL be performed solely by the datapath; the controller passes its result through unmodified.

Reset
REQ-020 RST_N=0 SHALL force, asynchronously, state IDLE, p=0, i=0, BUSY=0, DONE=0, SRAM_CS=0, SRAM_WE=0 and all address and data outputs 0.
REQ-021 Reset mid-sweep SHALL abandon the sweep with no further write; an aborted sweep SHALL NOT produce DONE.

Structure
REQ-022 A shared package SHALL hold the FSM state encoding and the default width constants (PRE_CNT_WIDTH, POST_CNT_WIDTH, WEIGHT_WIDTH).
REQ-023 SHALL instantiate exactly one sub-module, the existing ffstdp_update datapath, which is combinational between SRAM_RDATA and SRAM_WDATA.

Verification (PRE_ADDR_W=2, POST_ADDR_W=1)
REQ-024 Scenario 1: START with IS_TRAIN=0 -> DONE on the next cycle, zero SRAM_CS cycles.
REQ-025 Scenario 2: post counts {0,0}, START, IS_TRAIN=1 -> DONE at cycle 5, no SRAM access.
REQ-026 Scenario 3: post counts {3,0}, pre counts {1,2,0,4}, weights 0x10 -> 3 writes (pre 0, 1, 3), none at {0,2}, DONE at cycle 13; written values match a datapath reference model.
REQ-027 Scenario 4: weight 0x7F, positive delta -> written value 0x7F (saturated); weight 0x80, negative delta -> 0x80.
REQ-028 Scenario 5: START pulsed again during the sweep -> ignored, identical write trace; RST_N low at cycle 6 -> outputs 0 immediately, no DONE; a subsequent START runs a full sweep.

Source files
------------

// File: rtl/ffstdp_update_ctrl_pkg.sv
// Shared definitions for the FF-STDP weight-update controller:
// FSM state encoding and default count/weight widths.
package ffstdp_update_ctrl_pkg;

  localparam int DEF_PRE_CNT_WIDTH  = 8;
  localparam int DEF_POST_CNT_WIDTH = 7;
  localparam int DEF_WEIGHT_WIDTH   = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    POST_RD  = 3'd1,
    POST_CHK = 3'd2,
    SYN_RD   = 3'd3,
    SYN_WR   = 3'd4,
    FIN      = 3'd5
  } state_t;

endpackage

// File: rtl/ffstdp_update.sv
// Combinational FF-STDP weight update. The step magnitude is the smaller
// of the pre and post spike counts; positive samples potentiate, negative
// samples depress, and the result saturates to the signed weight range.
// Outside a training reference event the weight passes through unchanged.
module ffstdp_update #(
  parameter int PRE_CNT_WIDTH  = 8,
  parameter int POST_CNT_WIDTH = 7,
  parameter int WEIGHT_WIDTH   = 8
) (
  input  logic signed [WEIGHT_WIDTH-1:0]   weight,
  input  logic        [PRE_CNT_WIDTH-1:0]  pre_cnt,
  input  logic        [POST_CNT_WIDTH-1:0] post_cnt,
  input  logic                             is_pos,
  input  logic                             is_train,
  input  logic                             tref_event,
  output logic signed [WEIGHT_WIDTH-1:0]   weight_new
);

  localparam logic signed [31:0] W_MAX = (32'sd1 <<< (WEIGHT_WIDTH - 1)) - 32'sd1;
  localparam logic signed [31:0] W_MIN = -(32'sd1 <<< (WEIGHT_WIDTH - 1));

  function automatic logic signed [WEIGHT_WIDTH-1:0] sat_weight(input logic signed [31:0] v);
    logic signed [31:0] c;
    if (v > W_MAX)      c = W_MAX;
    else if (v < W_MIN) c = W_MIN;
    else                c = v;
    return c[WEIGHT_WIDTH-1:0];
  endfunction

  logic signed [31:0] w_ext;
  logic signed [31:0] pre_ext;
  logic signed [31:0] post_ext;
  logic signed [31:0] mag;
  logic signed [31:0] sum;

  // Widen, apply the signed step, then clamp to the weight range.
  always_comb begin
    w_ext    = 32'(weight);
    pre_ext  = 32'(pre_cnt);
    post_ext = 32'(post_cnt);
    mag      = (pre_ext < post_ext) ? pre_ext : post_ext;
    sum      = is_pos ? (w_ext + mag) : (w_ext - mag);
    if (is_train && tref_event) weight_new = sat_weight(sum);
    else                        weight_new = weight;
  end

endmodule

// File: rtl/ffstdp_update_ctrl.sv
// Sweeps every post neuron with a non-zero spike count and, for each, every
// pre neuron: read synapse, run the update datapath, write back when the
// pre count is non-zero. One START pulse per sweep, one DONE pulse at the end.
module ffstdp_update_ctrl
  import ffstdp_update_ctrl_pkg::*;
#(
  parameter int PRE_ADDR_W     = 8,
  parameter int POST_ADDR_W    = 7,
  parameter int PRE_CNT_WIDTH  = DEF_PRE_CNT_WIDTH,
  parameter int POST_CNT_WIDTH = DEF_POST_CNT_WIDTH,
  parameter int WEIGHT_WIDTH   = DEF_WEIGHT_WIDTH
) (
  input  logic                            CLK,
  input  logic                            RST_N,
  input  logic                            START,
  input  logic                            IS_TRAIN,
  input  logic                            IS_POS,
  output logic                            BUSY,
  output logic                            DONE,
  output logic [POST_ADDR_W-1:0]          POST_CNT_ADDR,
  input  logic [POST_CNT_WIDTH-1:0]       POST_CNT_RDATA,
  output logic [PRE_ADDR_W-1:0]           PRE_CNT_ADDR,
  input  logic [PRE_CNT_WIDTH-1:0]        PRE_CNT_RDATA,
  output logic                            SRAM_CS,
  output logic                            SRAM_WE,
  output logic [POST_ADDR_W+PRE_ADDR_W-1:0] SRAM_ADDR,
  output logic [WEIGHT_WIDTH-1:0]         SRAM_WDATA,
  input  logic [WEIGHT_WIDTH-1:0]         SRAM_RDATA
);

  state_t                     state, state_nxt;
  logic [POST_ADDR_W-1:0]     p, p_nxt;
  logic [PRE_ADDR_W-1:0]      i, i_nxt;
  logic                       is_pos_q, is_pos_nxt;
  logic [POST_CNT_WIDTH-1:0]  post_cnt_q;
  logic                       post_load;
  logic signed [WEIGHT_WIDTH-1:0] weight_new;

  // The count memories see the live indices; they only matter in the
  // cycle the FSM reads them.
  assign POST_CNT_ADDR = p;
  assign PRE_CNT_ADDR  = i;

  ffstdp_update #(
    .PRE_CNT_WIDTH  (PRE_CNT_WIDTH),
    .POST_CNT_WIDTH (POST_CNT_WIDTH),
    .WEIGHT_WIDTH   (WEIGHT_WIDTH)
  ) u_update (
    .weight     (SRAM_RDATA),
    .pre_cnt    (PRE_CNT_RDATA),
    .post_cnt   (post_cnt_q),
    .is_pos     (is_pos_q),
    .is_train   (1'b1),
    .tref_event (1'b1),
    .weight_new (weight_new)
  );

  // Control state: FSM, sweep indices and the sample polarity latched at START.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      p        <= '0;
      i        <= '0;
      is_pos_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      p        <= p_nxt;
      i        <= i_nxt;
      is_pos_q <= is_pos_nxt;
    end
  end

  // Post count held for the whole pre sweep of the current post neuron.
  always_ff @(posedge CLK) begin
    if (post_load) post_cnt_q <= POST_CNT_RDATA;
  end

  // Next-state, index stepping and memory-port decode.
  always_comb begin
    state_nxt  = state;
    p_nxt      = p;
    i_nxt      = i;
    is_pos_nxt = is_pos_q;
    post_load  = 1'b0;
    BUSY       = (state != IDLE);
    DONE       = 1'b0;
    SRAM_CS    = 1'b0;
    SRAM_WE    = 1'b0;
    SRAM_ADDR  = '0;
    SRAM_WDATA = '0;
    case (state)
      IDLE: begin
        if (START) begin
          if (IS_TRAIN) begin
            is_pos_nxt = IS_POS;
            p_nxt      = '0;
            i_nxt      = '0;
            state_nxt  = POST_RD;
          end else begin
            state_nxt  = FIN;
          end
        end
      end
      POST_RD: begin
        state_nxt = POST_CHK;
      end
      POST_CHK: begin
        if (POST_CNT_RDATA == '0) begin
          if (&p) begin
            state_nxt = FIN;
          end else begin
            p_nxt     = p + POST_ADDR_W'(1);
            state_nxt = POST_RD;
          end
        end else begin
          post_load = 1'b1;
          i_nxt     = '0;
          state_nxt = SYN_RD;
        end
      end
      SYN_RD: begin
        SRAM_CS   = 1'b1;
        SRAM_ADDR = {p, i};
        state_nxt = SYN_WR;
      end
      SYN_WR: begin
        SRAM_CS    = 1'b1;
        SRAM_WE    = (PRE_CNT_RDATA != '0);
        SRAM_ADDR  = {p, i};
        SRAM_WDATA = weight_new;
        if (&i) begin
          if (&p) begin
            state_nxt = FIN;
          end else begin
            p_nxt     = p + POST_ADDR_W'(1);
            state_nxt = POST_RD;
          end
        end else begin
          i_nxt     = i + PRE_ADDR_W'(1);
          state_nxt = SYN_RD;
        end
      end
      FIN: begin
        DONE      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
